// File: rtl/if_fetch_unit_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage: fetch-state
// encodings, the default reset PC, the NOP instruction word and small PC
// helper functions used by the fetch unit.
package if_fetch_unit_pkg;

    // Default PC loaded on reset when the parent does not override it.
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Instruction word presented before anything has been fetched.
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    // Fetch-state encoding, kept as plain constants so older tools that
    // consume this package see simple two-bit values.
    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t FETCH_STATE = 2'd0;  // request on the bus
    localparam fetch_state_t WAIT_STATE  = 2'd1;  // granted, awaiting data
    localparam fetch_state_t READY_STATE = 2'd2;  // instruction presented
    localparam fetch_state_t DROP_STATE  = 2'd3;  // squashing a stale response

    // Redirect targets are word addresses; the two low bits are dropped.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    // Sequential successor of a PC; the 32-bit add wraps naturally.
    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch unit. Holds the PC, issues one instruction-memory
// request at a time and presents the returned word to the IF/ID register
// until it is consumed. Branch/jump redirects always win over stalls; a
// response that was already in flight when a redirect arrived is
// squashed in the DROP state so it can never be presented.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_PCAdd4,
    output logic [31:0] IF_Inst,
    output logic        block
);

    fetch_state_t state_q;
    fetch_state_t state_d;
    logic [31:0]  pc_q;
    logic [31:0]  pc_d;
    logic         capture;
    logic [31:0]  redirect_pc;
    logic [31:0]  if_pc_q;
    logic [31:0]  if_pcadd4_q;
    logic [31:0]  if_inst_q;

    assign redirect_pc = align_word(redirect_target);

    // Next-state and next-PC selection; redirect is examined first in every state.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        capture = 1'b0;
        case (state_q)
            FETCH_STATE: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                end
                if (imem_gnt) begin
                    state_d = redirect ? DROP_STATE : WAIT_STATE;
                end
            end
            WAIT_STATE: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = imem_valid ? FETCH_STATE : DROP_STATE;
                end else if (imem_valid) begin
                    capture = 1'b1;
                    state_d = READY_STATE;
                end
            end
            READY_STATE: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = FETCH_STATE;
                end else if (!stall) begin
                    pc_d    = seq_pc(pc_q);
                    state_d = FETCH_STATE;
                end
            end
            DROP_STATE: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                end
                if (imem_valid) begin
                    state_d = FETCH_STATE;
                end
            end
            default: begin
                state_d = FETCH_STATE;
            end
        endcase
    end

    // FSM state and PC registers; reset abandons any outstanding request.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= FETCH_STATE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Presentation registers load only when a response is accepted in WAIT, so they stay frozen through READY.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            if_pc_q     <= RESET_PC;
            if_pcadd4_q <= seq_pc(RESET_PC);
            if_inst_q   <= NOP_INST;
        end else if (capture) begin
            if_pc_q     <= pc_q;
            if_pcadd4_q <= seq_pc(pc_q);
            if_inst_q   <= imem_rdata;
        end
    end

    assign imem_req  = (state_q == FETCH_STATE);
    assign imem_addr = pc_q;
    assign block     = (state_q != READY_STATE);
    assign IF_PC     = if_pc_q;
    assign IF_PCAdd4 = if_pcadd4_q;
    assign IF_Inst   = if_inst_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Testbench for if_fetch_unit: a table of directed cycle vectors, a
// hand-written reset-in-flight sequence, and a randomized phase driven by
// a small memory model and checked against a transaction-level model of
// which instruction must be presented next.
module tb_if_fetch_unit;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] IF_PC;
    logic [31:0] IF_PCAdd4;
    logic [31:0] IF_Inst;
    logic        block;

    int checks;
    int failures;

    if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clock(clock),
        .reset(reset),
        .stall(stall),
        .redirect(redirect),
        .redirect_target(redirect_target),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_gnt(imem_gnt),
        .imem_valid(imem_valid),
        .imem_rdata(imem_rdata),
        .IF_PC(IF_PC),
        .IF_PCAdd4(IF_PCAdd4),
        .IF_Inst(IF_Inst),
        .block(block)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic        stall;
        logic        redirect;
        logic [31:0] target;
        logic        gnt;
        logic        valid;
        logic [31:0] rdata;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_block;
        logic        chk_if;
        logic [31:0] exp_pc;
        logic [31:0] exp_pcadd4;
        logic [31:0] exp_inst;
    } vec_t;

    vec_t vecs[$];

    // Word stored at an address in the random-phase memory model.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic st, input logic rd, input logic [31:0] tg,
                       input logic gn, input logic vl, input logic [31:0] rdt,
                       input logic req, input logic [31:0] addr, input logic blk,
                       input logic chk, input logic [31:0] pc, input logic [31:0] pc4,
                       input logic [31:0] inst);
        vec_t v;
        v.name = name; v.stall = st; v.redirect = rd; v.target = tg;
        v.gnt = gn; v.valid = vl; v.rdata = rdt;
        v.exp_req = req; v.exp_addr = addr; v.exp_block = blk;
        v.chk_if = chk; v.exp_pc = pc; v.exp_pcadd4 = pc4; v.exp_inst = inst;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic st, input logic rd, input logic [31:0] tg,
                         input logic gn, input logic vl, input logic [31:0] rdt);
        stall = st; redirect = rd; redirect_target = tg;
        imem_gnt = gn; imem_valid = vl; imem_rdata = rdt;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        drive(v.stall, v.redirect, v.target, v.gnt, v.valid, v.rdata);
        step();
        checkOutput({v.name, "_req"}, {31'd0, imem_req}, {31'd0, v.exp_req});
        checkOutput({v.name, "_addr"}, imem_addr, v.exp_addr);
        checkOutput({v.name, "_block"}, {31'd0, block}, {31'd0, v.exp_block});
        if (v.chk_if) begin
            checkOutput({v.name, "_pc"}, IF_PC, v.exp_pc);
            checkOutput({v.name, "_pcadd4"}, IF_PCAdd4, v.exp_pcadd4);
            checkOutput({v.name, "_inst"}, IF_Inst, v.exp_inst);
        end
    endtask

    task automatic check_reset_values(input string name, input logic [31:0] rpc);
        checkOutput({name, "_block"}, {31'd0, block}, 32'd1);
        checkOutput({name, "_req"}, {31'd0, imem_req}, 32'd1);
        checkOutput({name, "_addr"}, imem_addr, rpc);
        checkOutput({name, "_pc"}, IF_PC, rpc);
        checkOutput({name, "_pcadd4"}, IF_PCAdd4, rpc + 32'd4);
        checkOutput({name, "_inst"}, IF_Inst, 32'h0);
    endtask

    // Random-phase model state
    logic [31:0] exp_pc;
    logic        outstanding;
    logic [31:0] out_addr;
    int          lat_cnt;
    logic        held;
    logic [31:0] saved_pc;
    logic [31:0] saved_inst;
    int          presentations;
    int          idle;

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

        // Directed vectors: {stall, redirect, target, gnt, valid, rdata} -> {req, addr, block, IF regs}
        add("r033_wait",   0,0,32'h0,        1,0,32'h0,         0,32'h0,        1, 0,32'h0,32'h0,32'h0);
        add("r033_ready",  0,0,32'h0,        0,1,32'h2010_0005, 0,32'h0,        0, 1,32'h0,32'h4,32'h2010_0005);
        add("r033_next",   0,0,32'h0,        0,0,32'h0,         1,32'h4,        1, 0,32'h0,32'h0,32'h0);
        add("r034_wait",   0,0,32'h0,        1,0,32'h0,         0,32'h4,        1, 0,32'h0,32'h0,32'h0);
        add("r034_ready",  0,0,32'h0,        0,1,32'h1111_2222, 0,32'h4,        0, 1,32'h4,32'h8,32'h1111_2222);
        add("r034_stall1", 1,0,32'h0,        0,0,32'h0,         0,32'h4,        0, 1,32'h4,32'h8,32'h1111_2222);
        add("r034_stall2", 1,0,32'h0,        1,0,32'h0,         0,32'h4,        0, 1,32'h4,32'h8,32'h1111_2222);
        add("r034_stall3", 1,0,32'h0,        0,0,32'h0,         0,32'h4,        0, 1,32'h4,32'h8,32'h1111_2222);
        add("r034_go",     0,0,32'h0,        0,0,32'h0,         1,32'h8,        1, 0,32'h0,32'h0,32'h0);
        add("r035_wait",   0,0,32'h0,        1,0,32'h0,         0,32'h8,        1, 0,32'h0,32'h0,32'h0);
        add("r035_redir",  0,1,32'h40,       0,0,32'h0,         0,32'h40,       1, 0,32'h0,32'h0,32'h0);
        add("r035_drop",   0,0,32'h0,        0,0,32'h0,         0,32'h40,       1, 0,32'h0,32'h0,32'h0);
        add("r035_squash", 0,0,32'h0,        0,1,32'hDEAD_BEEF, 1,32'h40,       1, 1,32'h4,32'h8,32'h1111_2222);
        add("r035_wait2",  0,0,32'h0,        1,0,32'h0,         0,32'h40,       1, 0,32'h0,32'h0,32'h0);
        add("r035_ready",  0,0,32'h0,        0,1,32'h0000_0013, 0,32'h40,       0, 1,32'h40,32'h44,32'h0000_0013);
        add("r036_both",   1,1,32'h103,      0,0,32'h0,         1,32'h100,      1, 0,32'h0,32'h0,32'h0);
        add("nogrant",     0,0,32'h0,        0,0,32'h0,         1,32'h100,      1, 0,32'h0,32'h0,32'h0);
        add("fetch_redir", 0,1,32'hFFFF_FFFE,0,0,32'h0,         1,32'hFFFF_FFFC,1, 0,32'h0,32'h0,32'h0);
        add("r037_wait",   0,0,32'h0,        1,0,32'h0,         0,32'hFFFF_FFFC,1, 0,32'h0,32'h0,32'h0);
        add("r037_ready",  0,0,32'h0,        0,1,32'hCAFE_0001, 0,32'hFFFF_FFFC,0, 1,32'hFFFF_FFFC,32'h0,32'hCAFE_0001);
        add("r037_wrap",   0,0,32'h0,        0,0,32'h0,         1,32'h0,        1, 0,32'h0,32'h0,32'h0);
        add("wv_wait",     0,0,32'h0,        1,0,32'h0,         0,32'h0,        1, 0,32'h0,32'h0,32'h0);
        add("wv_redir",    0,1,32'h200,      0,1,32'h0BAD_0BAD, 1,32'h200,      1, 1,32'hFFFF_FFFC,32'h0,32'hCAFE_0001);
        add("fg_redir",    0,1,32'h300,      1,0,32'h0,         0,32'h300,      1, 0,32'h0,32'h0,32'h0);
        add("drop_latest", 0,1,32'h305,      0,0,32'h0,         0,32'h304,      1, 0,32'h0,32'h0,32'h0);
        add("drop_valid",  0,0,32'h0,        0,1,32'h0BAD_F00D, 1,32'h304,      1, 0,32'h0,32'h0,32'h0);
        add("spur_fetch",  0,0,32'h0,        0,1,32'h0BAD_F00D, 1,32'h304,      1, 0,32'h0,32'h0,32'h0);
        add("rf_wait",     0,0,32'h0,        1,0,32'h0,         0,32'h304,      1, 0,32'h0,32'h0,32'h0);
        add("rf_ready",    0,0,32'h0,        0,1,32'h1234_5678, 0,32'h304,      0, 1,32'h304,32'h308,32'h1234_5678);
        add("spur_ready",  1,0,32'h0,        0,1,32'h0BAD_F00D, 0,32'h304,      0, 1,32'h304,32'h308,32'h1234_5678);
        add("rf_go",       0,0,32'h0,        0,0,32'h0,         1,32'h308,      1, 0,32'h0,32'h0,32'h0);

        // Reset state, then release and check the request is up immediately
        step();
        check_reset_values("reset", 32'h0);
        reset = 1'b0;
        step();
        checkOutput("post_reset_req", {31'd0, imem_req}, 32'd1);
        checkOutput("post_reset_addr", imem_addr, 32'h0);

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Reset asserted between edges while a request is outstanding
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        step();
        checkOutput("r038_in_wait", {31'd0, imem_req}, 32'd0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #3;
        reset = 1'b1;
        #1;
        check_reset_values("r038_async", 32'h0);
        step();
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        step();
        checkOutput("r038_late_valid_block", {31'd0, block}, 32'd1);
        checkOutput("r038_late_valid_req", {31'd0, imem_req}, 32'd1);
        checkOutput("r038_first_addr", imem_addr, 32'h0);
        checkOutput("r038_inst_clear", IF_Inst, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        step();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hABCD_0001);
        step();
        checkOutput("r038_refetch_block", {31'd0, block}, 32'd0);
        checkOutput("r038_refetch_inst", IF_Inst, 32'hABCD_0001);
        checkOutput("r038_refetch_pc", IF_PC, 32'h0);

        // Randomized phase against the next-instruction model
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step();
        reset = 1'b0;
        exp_pc = 32'h0;
        outstanding = 1'b0;
        out_addr = 32'h0;
        lat_cnt = 0;
        held = 1'b0;
        saved_pc = 32'h0;
        saved_inst = 32'h0;
        presentations = 0;
        idle = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            logic        st;
            logic        rd;
            logic [31:0] tg;
            logic        gn;
            logic        vl;
            logic [31:0] rdt;

            if (imem_req) begin
                checkOutput("rnd_addr", imem_addr, exp_pc);
                checkOutput("rnd_single_outstanding", {31'd0, outstanding}, 32'd0);
            end
            if (held) begin
                checkOutput("rnd_hold_block", {31'd0, block}, 32'd0);
                checkOutput("rnd_hold_pc", IF_PC, saved_pc);
                checkOutput("rnd_hold_pcadd4", IF_PCAdd4, saved_pc + 32'd4);
                checkOutput("rnd_hold_inst", IF_Inst, saved_inst);
            end else if (!block) begin
                checkOutput("rnd_pc", IF_PC, exp_pc);
                checkOutput("rnd_pcadd4", IF_PCAdd4, exp_pc + 32'd4);
                checkOutput("rnd_inst", IF_Inst, mem_word(exp_pc));
                saved_pc = exp_pc;
                saved_inst = mem_word(exp_pc);
                presentations++;
                idle = 0;
            end else begin
                idle++;
            end
            if (idle > 300) begin
                checks++;
                failures++;
                $display("[TB] FAIL rnd_progress: idle %0d cycles, limit 300", idle);
                break;
            end

            st = ($urandom % 3) == 0;
            rd = ($urandom % 12) == 0;
            if (($urandom % 4) == 0) tg = 32'hFFFF_FFF0 | ($urandom % 16);
            else tg = $urandom & 32'h0000_3FFF;
            gn = ($urandom % 2) == 0;
            vl = 1'b0;
            rdt = $urandom;
            if (outstanding) begin
                if (lat_cnt == 0) begin
                    vl = 1'b1;
                    rdt = mem_word(out_addr);
                end else begin
                    lat_cnt--;
                end
            end else begin
                vl = ($urandom % 8) == 0;
            end
            drive(st, rd, tg, gn, vl, rdt);

            held = !block && st && !rd;
            if (rd) exp_pc = {tg[31:2], 2'b00};
            else if (!block && !st) exp_pc = exp_pc + 32'd4;
            if (vl && outstanding) outstanding = 1'b0;
            if (imem_req && gn) begin
                outstanding = 1'b1;
                out_addr = imem_addr;
                lat_cnt = $urandom % 4;
            end
            step();
        end
        checks++;
        if (presentations < 50) begin
            failures++;
            $display("[TB] FAIL rnd_presentations: got %0d expected at least 50", presentations);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
